stage3_mem_arbiter: RTL and testbench
=====================================

Name: stage3_mem_arbiter

Overview:
- Shares one generic memory bus port between the 3-stage pipeline's instruction-fetch requester and data-access requester.
- Provides fixed data-over-fetch priority with a starvation guard, and never preempts a transaction in flight.
- Safely drains a transaction whose requester withdraws it, e.g. on PC redirect or exception suppression.
- Sits between the fetch/memory stages, which see per-requester busy signals, and the single bus to cache/memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits before fetch is forced; range 1..15.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- i_ren  in  1  fetch request
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetch read data; valid when i_busy low and i_ren high
- i_busy  out  1  high until fetch transaction completes
- d_ren  in  1  data read request
- d_wen  in  1  data write request; d_ren and d_wen are mutually exclusive
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_byte_en  in  DATA_W/8  byte enables
- d_rdata  out  DATA_W  data read data
- d_busy  out  1  high until data transaction completes
- bus_ren  out  1  bus read
- bus_wen  out  1  bus write
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_byte_en  out  DATA_W/8  bus byte enables; all ones for fetch
- bus_rdata  in  DATA_W  bus read data
- bus_busy  in  1  bus busy; low means the current transaction completes this cycle

Behaviour:

Reset values:
- State IDLE; bus_ren, bus_wen, bus_addr, bus_wdata, bus_byte_en all 0.
- i_busy and d_busy both 1; starvation counter 0.

FSM states: IDLE, IGRANT, DGRANT, DRAIN.
- IDLE: on the next edge, latch the winner's address/data/byte_en/direction into registers.
  - Data wins if present, unless the counter has reached STARVE_LIMIT and i_ren is high.
  - Data win -> DGRANT; fetch win -> IGRANT; no request -> stay IDLE.
- One-cycle arbitration latency. Bus outputs are driven only from the latched registers, and only in the grant/drain states; in IDLE they are 0.
- IGRANT/DGRANT: hold bus signals stable.
  - On bus_busy low, the owner's busy goes low the same cycle and rdata passes bus_rdata through combinationally; next state IDLE. Back-to-back grants therefore have 1 idle cycle.
  - Withdrawal: owner's request drops, or its address changes, before completion -> next state DRAIN. Bus signals are held and busy stays high.
- DRAIN: keep the latched transaction on the bus until bus_busy low, discard the response, assert no busy-low to anyone, then IDLE.
  - A pending write in drain still completes; suppression must act before grant.
- Non-owner busy stays high while any transaction is active or the state is DRAIN.
- Starvation counter:
  - Increments (saturating at 15) on each data grant issued while i_ren is high.
  - Clears on any fetch grant, or when i_ren is low in IDLE.
- Requests that drop before the IDLE grant edge produce no bus activity.
- RST mid-transaction forces IDLE on the next edge; the downstream bus is reset by the same RST.

Optional Feature:
- Macro STAGE3_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_i_wait, perf_d_wait and perf_drain, each 32-bit.
  - perf_i_wait and perf_d_wait increment each cycle the respective request is high and its busy is high.
  - perf_drain increments on each entry to DRAIN.
  - All wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (e.g. the bus types package): arb_state_t enum (IDLE, IGRANT, DGRANT, DRAIN), the bus_req_t struct {ren, wen, addr, wdata, byte_en}, and STARVE_CNT_W = 4.
- One natural sub-module, stage3_arb_starve_ctr: the saturating counter with a force_fetch output.

Test Plan:
1. Simultaneous i_ren=1 (0x100) and d_ren=1 (0x2000), bus_busy low after 2 cycles -> bus_addr=0x2000 first, d_busy falls; then bus_addr=0x100 after 1 IDLE cycle.
2. Continuous d_ren with i_ren held, STARVE_LIMIT=4 -> exactly 4 data grants, then a fetch grant, then the counter returns to 0.
3. Fetch granted at 0x100, i_ren drops before bus_busy low, with bus_busy held 3 cycles -> DRAIN, bus_addr stays 0x100, no i_busy low pulse, IDLE after completion.
4. d_wen with byte_en=4'b0011 and wdata=0xDEADBEEF -> bus_wen=1 with identical fields held stable until bus_busy low; fetch grant shows bus_byte_en=4'hF.
5. RST asserted during DGRANT -> next cycle state IDLE, bus outputs 0, both busy outputs 1.
6. With STAGE3_ARB_PERF_EN: fetch waits 5 cycles -> perf_i_wait=5; one drain -> perf_drain=1.

Source files
------------

// File: rtl/stage3_mem_arbiter_pkg.sv
// Shared types for the fetch/data memory-bus arbiter: FSM states, the latched
// bus request record and the starvation counter width.
package stage3_mem_arbiter_pkg;

  localparam int unsigned BUS_ADDR_W   = 32;
  localparam int unsigned BUS_DATA_W   = 32;
  localparam int unsigned STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIgrant,
    StDgrant,
    StDrain
  } arb_state_t;

  typedef struct packed {
    logic                    ren;
    logic                    wen;
    logic [BUS_ADDR_W-1:0]   addr;
    logic [BUS_DATA_W-1:0]   wdata;
    logic [BUS_DATA_W/8-1:0] byte_en;
  } bus_req_t;

endpackage

// File: rtl/stage3_mem_arbiter_if.sv
// Requester and memory-bus signals of the arbiter. The slave modport is the
// arbiter's view; master is the view of the surrounding pipeline and memory.
interface stage3_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  i_ren;
  logic [ADDR_W-1:0]     i_addr;
  logic [DATA_W-1:0]     i_rdata;
  logic                  i_busy;

  logic                  d_ren;
  logic                  d_wen;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_byte_en;
  logic [DATA_W-1:0]     d_rdata;
  logic                  d_busy;

  logic                  bus_ren;
  logic                  bus_wen;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic [DATA_W/8-1:0]   bus_byte_en;
  logic [DATA_W-1:0]     bus_rdata;
  logic                  bus_busy;

  modport slave (
    input  i_ren, i_addr, d_ren, d_wen, d_addr, d_wdata, d_byte_en, bus_rdata, bus_busy,
    output i_rdata, i_busy, d_rdata, d_busy,
    output bus_ren, bus_wen, bus_addr, bus_wdata, bus_byte_en
  );

  modport master (
    output i_ren, i_addr, d_ren, d_wen, d_addr, d_wdata, d_byte_en, bus_rdata, bus_busy,
    input  i_rdata, i_busy, d_rdata, d_busy,
    input  bus_ren, bus_wen, bus_addr, bus_wdata, bus_byte_en
  );
endinterface

// File: rtl/stage3_arb_starve_ctr.sv
// Saturating count of data grants issued while fetch waits; force_fetch rises
// once the count reaches STARVE_LIMIT.
module stage3_arb_starve_ctr
  import stage3_mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic fetch_req,
  input  logic data_grant,
  input  logic fetch_grant,
  output logic force_fetch
);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (fetch_grant || (idle && !fetch_req)) begin
      cnt_d = '0;
    end else if (data_grant && fetch_req && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_fetch = (cnt_q >= STARVE_CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/stage3_mem_arbiter.sv
// Fetch/data arbiter onto one memory bus: data-first priority with a starvation
// guard, no preemption, and draining of withdrawn transactions.
// Optional perf counters are enabled by defining STAGE3_ARB_PERF_EN.
module stage3_mem_arbiter
  import stage3_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = BUS_ADDR_W,
  parameter int unsigned DATA_W       = BUS_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  stage3_mem_arbiter_if.slave  arb
`ifdef STAGE3_ARB_PERF_EN
  ,
  output logic [31:0]          perf_i_wait,
  output logic [31:0]          perf_d_wait,
  output logic [31:0]          perf_drain
`endif
);

  arb_state_t          state_q, state_d;
  bus_req_t            req_q, req_d;
  logic                d_req, data_win, fetch_win, force_fetch, idle, bus_on;
  logic                withdraw, i_busy_c, d_busy_c;
  logic [ADDR_W-1:0]   owner_addr;
  logic [DATA_W/8-1:0] fetch_be;

  assign fetch_be  = '1;
  assign d_req     = arb.d_ren | arb.d_wen;
  assign idle      = (state_q == StIdle);
  assign data_win  = d_req & ~(force_fetch & arb.i_ren);
  assign fetch_win = arb.i_ren & ~data_win;

  // The owner withdraws by dropping its request or moving to another address.
  assign owner_addr = (state_q == StIgrant) ? arb.i_addr : arb.d_addr;
  assign withdraw   = ((state_q == StIgrant) ? ~arb.i_ren : ~d_req) |
                      (owner_addr != req_q.addr);

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    i_busy_c = 1'b1;
    d_busy_c = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (data_win) begin
          state_d       = StDgrant;
          req_d.ren     = arb.d_ren;
          req_d.wen     = arb.d_wen;
          req_d.addr    = arb.d_addr;
          req_d.wdata   = arb.d_wen ? arb.d_wdata : '0;
          req_d.byte_en = arb.d_byte_en;
        end else if (fetch_win) begin
          state_d       = StIgrant;
          req_d.ren     = 1'b1;
          req_d.wen     = 1'b0;
          req_d.addr    = arb.i_addr;
          req_d.wdata   = '0;
          req_d.byte_en = fetch_be;
        end
      end
      StIgrant, StDgrant: begin
        if (!arb.bus_busy) begin
          // A withdrawal in the completion cycle still ends the transaction, silently.
          state_d = StIdle;
          if (!withdraw) begin
            i_busy_c = (state_q != StIgrant);
            d_busy_c = (state_q != StDgrant);
          end
        end else if (withdraw) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (!arb.bus_busy) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  stage3_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk         (CLK),
    .rst         (RST),
    .idle        (idle),
    .fetch_req   (arb.i_ren),
    .data_grant  (idle & data_win),
    .fetch_grant (idle & fetch_win),
    .force_fetch (force_fetch)
  );

  assign bus_on          = ~idle;
  assign arb.bus_ren     = bus_on & req_q.ren;
  assign arb.bus_wen     = bus_on & req_q.wen;
  assign arb.bus_addr    = bus_on ? req_q.addr    : '0;
  assign arb.bus_wdata   = bus_on ? req_q.wdata   : '0;
  assign arb.bus_byte_en = bus_on ? req_q.byte_en : '0;
  assign arb.i_rdata     = arb.bus_rdata;
  assign arb.d_rdata     = arb.bus_rdata;
  assign arb.i_busy      = i_busy_c;
  assign arb.d_busy      = d_busy_c;

`ifdef STAGE3_ARB_PERF_EN
  logic [31:0] perf_i_wait_q, perf_d_wait_q, perf_drain_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_i_wait_q <= '0;
      perf_d_wait_q <= '0;
      perf_drain_q  <= '0;
    end else begin
      if (arb.i_ren && i_busy_c) perf_i_wait_q <= perf_i_wait_q + 32'd1;
      if (d_req && d_busy_c)     perf_d_wait_q <= perf_d_wait_q + 32'd1;
      if ((state_d == StDrain) && (state_q != StDrain)) perf_drain_q <= perf_drain_q + 32'd1;
    end
  end

  assign perf_i_wait = perf_i_wait_q;
  assign perf_d_wait = perf_d_wait_q;
  assign perf_drain  = perf_drain_q;
`endif

endmodule

// File: tb/tb_stage3_mem_arbiter.sv
// Scoreboard bench for stage3_mem_arbiter: expected bus transactions are queued
// as requests are driven and checked when they appear on the bus.
module tb_stage3_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stage3_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) arb_if ();

`ifdef STAGE3_ARB_PERF_EN
  logic [31:0] perf_i_wait, perf_d_wait, perf_drain;
`endif

  stage3_mem_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (4)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .arb (arb_if)
`ifdef STAGE3_ARB_PERF_EN
    ,
    .perf_i_wait (perf_i_wait),
    .perf_d_wait (perf_d_wait),
    .perf_drain  (perf_drain)
`endif
  );

  typedef struct {
    bit          fetch;
    bit          wen;
    bit          drain;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   lat   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return ~a ^ 32'h1234_5678;
  endfunction

  task automatic push_exp(input bit fetch, input bit wen, input bit drain,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be);
    exp_t e;
    e.fetch = fetch; e.wen = wen; e.drain = drain;
    e.addr = addr; e.wdata = wdata; e.be = be;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits for the requester's busy to drop, then returns just after the next edge.
  task automatic wait_done(input bit is_fetch, input string tag);
    logic b;
    b = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      b = is_fetch ? arb_if.i_busy : arb_if.d_busy;
      if (!b) break;
    end
    if (b) check(tag, 64'(b), 64'd0);
    step(1);
  endtask

  task automatic wait_bus(input bit want_active, input string tag);
    logic a;
    a = ~want_active;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      a = arb_if.bus_ren | arb_if.bus_wen;
      if (a == want_active) break;
    end
    if (a != want_active) check(tag, 64'(a), 64'(want_active));
  endtask

  // Memory model: busy for 'lat' cycles of a transaction, then done.
  initial begin : responder
    int beat;
    beat = 0;
    arb_if.bus_busy  = 1'b1;
    arb_if.bus_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (arb_if.bus_ren | arb_if.bus_wen) begin
        arb_if.bus_busy  = (beat < lat);
        arb_if.bus_rdata = rd_model(arb_if.bus_addr);
        beat++;
      end else begin
        beat = 0;
        arb_if.bus_busy  = 1'b1;
        arb_if.bus_rdata = '0;
      end
    end
  end

  initial begin : monitor
    exp_t        cur;
    logic        active, prev_active, gap_due, exp_ib, exp_db;
    logic [31:0] prev_addr;
    logic [37:0] prev_ctl, ctl;
    prev_active = 1'b0; gap_due = 1'b0; prev_addr = '0; prev_ctl = '0;
    cur = '{default: '0};
    forever begin
      @(negedge clk);
      active = arb_if.bus_ren | arb_if.bus_wen;
      ctl = {arb_if.bus_ren, arb_if.bus_wen, arb_if.bus_byte_en, arb_if.bus_wdata};
      if (rst) begin
        prev_active = 1'b0;
        gap_due     = 1'b0;
      end else begin
        exp_ib = 1'b1;
        exp_db = 1'b1;
        if (gap_due) check("idle_gap", 64'(active), 64'd0);
        gap_due = 1'b0;
        if (active && !prev_active) begin
          if (exp_q.size() == 0) begin
            check("unexpected_txn", 64'(arb_if.bus_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            cur = '{default: '0};
            cur.drain = 1'b1;
          end else begin
            cur = exp_q.pop_front();
            check("txn_addr", 64'(arb_if.bus_addr), 64'(cur.addr));
            check("txn_dir", {62'd0, arb_if.bus_ren, arb_if.bus_wen}, {62'd0, ~cur.wen, cur.wen});
            check("txn_be", 64'(arb_if.bus_byte_en), 64'(cur.be));
            if (cur.wen) check("txn_wdata", 64'(arb_if.bus_wdata), 64'(cur.wdata));
          end
        end else if (active) begin
          check("hold_addr", 64'(arb_if.bus_addr), 64'(prev_addr));
          check("hold_ctl", 64'(ctl), 64'(prev_ctl));
        end
        if (active && !arb_if.bus_busy) begin
          gap_due = 1'b1;
          if (!cur.drain) begin
            if (cur.fetch) begin
              exp_ib = 1'b0;
              check("i_rdata", 64'(arb_if.i_rdata), 64'(rd_model(cur.addr)));
            end else begin
              exp_db = 1'b0;
              if (!cur.wen) check("d_rdata", 64'(arb_if.d_rdata), 64'(rd_model(cur.addr)));
            end
          end
        end
        check("i_busy", 64'(arb_if.i_busy), 64'(exp_ib));
        check("d_busy", 64'(arb_if.d_busy), 64'(exp_db));
        prev_active = active;
      end
      prev_addr = arb_if.bus_addr;
      prev_ctl  = ctl;
    end
  end

  initial begin : main
    arb_if.i_ren = 1'b0; arb_if.i_addr = '0;
    arb_if.d_ren = 1'b0; arb_if.d_wen = 1'b0; arb_if.d_addr = '0;
    arb_if.d_wdata = '0; arb_if.d_byte_en = 4'hF;

    // Reset state
    step(3);
    @(negedge clk);
    check("rst_bus", {arb_if.bus_ren, arb_if.bus_wen, arb_if.bus_byte_en, arb_if.bus_wdata,
                      arb_if.bus_addr[25:0]}, 64'd0);
    check("rst_busy", {62'd0, arb_if.i_busy, arb_if.d_busy}, 64'd3);
    step(1);
    rst = 1'b0;
    step(2);

    // 1: simultaneous requests, data first, then fetch after one idle cycle
    lat = 2;
    arb_if.i_ren = 1'b1; arb_if.i_addr = 32'h100;
    arb_if.d_ren = 1'b1; arb_if.d_addr = 32'h2000;
    push_exp(1'b0, 1'b0, 1'b0, 32'h2000, 32'h0, 4'hF);
    push_exp(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 4'hF);
    wait_done(1'b0, "t1_d_timeout");
    arb_if.d_ren = 1'b0;
    wait_done(1'b1, "t1_i_timeout");
    arb_if.i_ren = 1'b0;
    step(2);

    // 2: starvation guard: four data grants, a forced fetch, then data again
    lat = 0;
    arb_if.i_ren = 1'b1; arb_if.i_addr = 32'h100;
    arb_if.d_ren = 1'b1; arb_if.d_addr = 32'h3000;
    for (int k = 0; k < 4; k++) push_exp(1'b0, 1'b0, 1'b0, 32'h3000, 32'h0, 4'hF);
    push_exp(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 4'hF);
    push_exp(1'b0, 1'b0, 1'b0, 32'h3000, 32'h0, 4'hF);
    for (int k = 0; k < 4; k++) wait_done(1'b0, "t2_d_timeout");
    wait_done(1'b1, "t2_i_timeout");
    wait_done(1'b0, "t2_d2_timeout");
    arb_if.i_ren = 1'b0; arb_if.d_ren = 1'b0;
    step(2);

    // 5: reset during a data grant
    lat = 5;
    arb_if.d_ren = 1'b1; arb_if.d_addr = 32'h6000;
    push_exp(1'b0, 1'b0, 1'b0, 32'h6000, 32'h0, 4'hF);
    wait_bus(1'b1, "t5_grant_timeout");
    step(1);
    rst = 1'b1; arb_if.d_ren = 1'b0;
    @(negedge clk);
    check("t5_bus_ren", 64'(arb_if.bus_ren), 64'd1);
    step(1);
    @(negedge clk);
    check("t5_bus_zero", {arb_if.bus_ren, arb_if.bus_wen, arb_if.bus_byte_en,
                          arb_if.bus_addr}, 64'd0);
    check("t5_busy", {62'd0, arb_if.i_busy, arb_if.d_busy}, 64'd3);
    step(1);
    rst = 1'b0;
    step(1);

`ifdef STAGE3_ARB_PERF_EN
    // Perf: fetch waits exactly five cycles with a four-cycle memory latency
    check("perf_rst", {perf_i_wait, perf_drain}, 64'd0);
    lat = 4;
    arb_if.i_ren = 1'b1; arb_if.i_addr = 32'h180;
    push_exp(1'b1, 1'b0, 1'b0, 32'h180, 32'h0, 4'hF);
    wait_done(1'b1, "perf_i_timeout");
    arb_if.i_ren = 1'b0;
    @(negedge clk);
    check("perf_i_wait", 64'(perf_i_wait), 64'd5);
    check("perf_d_wait", 64'(perf_d_wait), 64'd0);
    step(1);
`endif

    // 3: fetch withdrawn mid-transaction drains with no busy pulse
    lat = 3;
    arb_if.i_ren = 1'b1; arb_if.i_addr = 32'h100;
    push_exp(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 4'hF);
    wait_bus(1'b1, "t3_grant_timeout");
    step(1);
    arb_if.i_ren = 1'b0;
    wait_bus(1'b0, "t3_drain_timeout");
`ifdef STAGE3_ARB_PERF_EN
    check("perf_drain", 64'(perf_drain), 64'd1);
`endif
    step(2);

    // Data withdrawn by address change, then the new address is served
    lat = 2;
    arb_if.d_ren = 1'b1; arb_if.d_addr = 32'h4000;
    push_exp(1'b0, 1'b0, 1'b1, 32'h4000, 32'h0, 4'hF);
    push_exp(1'b0, 1'b0, 1'b0, 32'h4004, 32'h0, 4'hF);
    wait_bus(1'b1, "t3b_grant_timeout");
    step(1);
    arb_if.d_addr = 32'h4004;
    wait_done(1'b0, "t3b_d_timeout");
    arb_if.d_ren = 1'b0;
    step(2);

    // 4: partial write held stable, then a fetch with full byte enables
    lat = 2;
    arb_if.d_wen = 1'b1; arb_if.d_addr = 32'h5000;
    arb_if.d_wdata = 32'hDEAD_BEEF; arb_if.d_byte_en = 4'b0011;
    push_exp(1'b0, 1'b1, 1'b0, 32'h5000, 32'hDEAD_BEEF, 4'b0011);
    wait_done(1'b0, "t4_d_timeout");
    arb_if.d_wen = 1'b0; arb_if.d_byte_en = 4'hF; arb_if.d_wdata = '0;
    arb_if.i_ren = 1'b1; arb_if.i_addr = 32'h104;
    push_exp(1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 4'hF);
    wait_done(1'b1, "t4_i_timeout");
    arb_if.i_ren = 1'b0;
    step(2);

    // Request dropped before the grant edge: no bus activity
    arb_if.i_ren = 1'b1; arb_if.i_addr = 32'h700;
    @(negedge clk);
    arb_if.i_ren = 1'b0;
    step(6);

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
